// File: rtl/shift4_deser_rx.sv
// shift4_deser_rx: receive end of the 4-bit shift-register datapath.
// Collects one serial bit per accepted beat into an assembly register.
// Each finished word is moved into a holding register that is offered
// on a valid/ready handshake. Non-final beats are always accepted, so
// the next word can assemble while the previous one is still held.
// Optional feature macro: SHIFT4_RX_PARITY_EN adds one even-parity bit
// per frame, sets parity_err, and enables the PARITY state.
module shift4_deser_rx #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sin_valid,
   input  logic             sin_data,
   output logic             sin_ready,
   input  logic             dir,
   input  logic             inv,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             parity_err
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_PARITY  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] asm_q;
   logic [WIDTH-1:0] asm_next;
   logic [WIDTH-1:0] xfer_word;
   logic             dir_q;
   logic             inv_q;
   logic             cur_dir;
   logic             cur_inv;
   logic             last_data;
   logic             final_pend;
   logic             accept;
   logic             xfer;

   // Next assembly value and which beat completes the frame; dir/inv come
   // straight from the pins on the first bit, then from the latched copies.
   always_comb begin
      cur_dir   = (state == S_IDLE) ? dir : dir_q;
      cur_inv   = (state == S_IDLE) ? inv : inv_q;
      asm_next  = cur_dir ? {asm_q[WIDTH-2:0], sin_data}
                          : {sin_data, asm_q[WIDTH-1:1]};
      last_data = (state == S_COLLECT) && (cnt == LAST_CNT);
`ifdef SHIFT4_RX_PARITY_EN
      // The parity bit does not shift in; the data is already complete.
      final_pend = (state == S_PARITY);
      xfer_word  = inv_q ? ~asm_q : asm_q;
`else
      final_pend = last_data;
      xfer_word  = cur_inv ? ~asm_next : asm_next;
`endif
   end

   // Only the frame-completing beat can stall, and only while a word is
   // held that the consumer is not taking this cycle.
   assign sin_ready = ~final_pend | ~word_valid | word_ready;
   assign accept    = sin_valid & sin_ready;
   assign xfer      = accept & final_pend;

`ifndef SHIFT4_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

   // Receive FSM, assembly shift register and output holding register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         asm_q      <= '0;
         dir_q      <= 1'b0;
         inv_q      <= 1'b0;
         word_out   <= '0;
         word_valid <= 1'b0;
`ifdef SHIFT4_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         // A new word on the same edge as a consume keeps valid high.
         if (xfer) begin
            word_out   <= xfer_word;
            word_valid <= 1'b1;
         end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
         end

         if (accept) begin
            case (state)
               S_IDLE: begin
                  dir_q <= dir;
                  inv_q <= inv;
                  asm_q <= asm_next;
                  cnt   <= CNT_W'(1);
                  state <= S_COLLECT;
               end
               S_COLLECT: begin
                  asm_q <= asm_next;
                  if (last_data) begin
                     cnt <= '0;
`ifdef SHIFT4_RX_PARITY_EN
                     state <= S_PARITY;
`else
                     state <= S_IDLE;
`endif
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
`ifdef SHIFT4_RX_PARITY_EN
               S_PARITY: begin
                  parity_err <= (^asm_q) ^ sin_data;
                  state      <= S_IDLE;
               end
`endif
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_shift4_deser_rx.sv
// tb_shift4_deser_rx: directed and random stimulus for shift4_deser_rx.
// The reference model keeps the bits of the frame in progress and the
// held words in queues, and builds each word arithmetically from the bit
// order, inversion and parity rules.
module tb_shift4_deser_rx;

   localparam int WIDTH = 4;
`ifdef SHIFT4_RX_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif
   localparam int CNT_W = $clog2(FRAME);

   logic             clk = 1'b0;
   logic             reset;
   logic             sin_valid;
   logic             sin_data;
   logic             sin_ready;
   logic             dir;
   logic             inv;
   logic [WIDTH-1:0] word_out;
   logic             word_valid;
   logic             word_ready;
   logic             parity_err;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit               cur[$];
   logic [WIDTH:0]   held[$];
   logic             w_dir;
   logic             w_inv;
   logic [WIDTH-1:0] last_out  = '0;
   logic             last_perr = 1'b0;
   bit               last_acc;

   shift4_deser_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .sin_valid (sin_valid),
      .sin_data  (sin_data),
      .sin_ready (sin_ready),
      .dir       (dir),
      .inv       (inv),
      .word_out  (word_out),
      .word_valid(word_valid),
      .word_ready(word_ready),
      .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Word from the collected frame: first bit lands in the MSB (dir=1)
   // or the LSB (dir=0); parity is over the data before inversion.
   function automatic logic [WIDTH:0] build_word();
      logic [WIDTH-1:0] d;
      logic             p;
      d = '0;
      p = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (w_dir) d[WIDTH-1-i] = cur[i];
         else       d[i]         = cur[i];
      end
`ifdef SHIFT4_RX_PARITY_EN
      p = (^d) ^ cur[WIDTH];
`endif
      return {p, (w_inv ? ~d : d)};
   endfunction

   // One clock: check outputs at the negedge against the model, then
   // advance the model across the posedge.
   task automatic step();
      bit             exp_rdy;
      bit             acc;
      bit             pop;
      logic [WIDTH:0] e;
      @(negedge clk);
      exp_rdy = !((cur.size() == FRAME - 1) && (held.size() != 0) && !word_ready);
      chk("sin_ready", sin_ready, exp_rdy);
      chk("word_valid", word_valid, held.size() != 0);
      chk("word_out", word_out, last_out);
      chk("parity_err", parity_err, last_perr);
      acc      = sin_valid && exp_rdy;
      pop      = (held.size() != 0) && word_ready;
      last_acc = acc;
      @(posedge clk);
      if (!reset) begin
         cur.delete();
         held.delete();
         last_out  = '0;
         last_perr = 1'b0;
      end else begin
         if (pop) void'(held.pop_front());
         if (acc) begin
            if (cur.size() == 0) begin
               w_dir = dir;
               w_inv = inv;
            end
            cur.push_back(sin_data);
            if (cur.size() == FRAME) begin
               e = build_word();
               held.push_back(e);
               last_out  = e[WIDTH-1:0];
               last_perr = e[WIDTH];
               cur.delete();
            end
         end
      end
      #1;
   endtask

   task automatic send_bit(input logic b);
      int n;
      sin_valid = 1'b1;
      sin_data  = b;
      n = 0;
      do begin
         step();
         n++;
      end while (!last_acc && n < 20);
      if (!last_acc) begin
         checks++;
         errors++;
         $error("FAIL send_timeout: observed no accept after %0d cycles expected accept", n);
      end
      sin_valid = 1'b0;
   endtask

   // seq[3] goes first; toggle flips dir after the first bit; flip corrupts parity.
   task automatic send_word(input logic d, input logic i, input logic [3:0] seq,
                            input logic toggle, input logic flip);
      dir = d;
      inv = i;
      for (int k = 0; k < WIDTH; k++) begin
         send_bit(seq[WIDTH-1-k]);
         if (k == 0 && toggle) dir = ~dir;
      end
`ifdef SHIFT4_RX_PARITY_EN
      send_bit((^seq) ^ flip);
`else
      if (flip) $display("note: parity flip ignored without parity");
`endif
   endtask

   initial begin
      reset      = 1'b0;
      sin_valid  = 1'b0;
      sin_data   = 1'b0;
      dir        = 1'b1;
      inv        = 1'b0;
      word_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      chk("rst_word_out", word_out, 0);
      chk("rst_word_valid", word_valid, 0);
      chk("rst_parity_err", parity_err, 0);
      chk("rst_sin_ready", sin_ready, 1);

      // MSB-first, no inversion
      send_word(1'b1, 1'b0, 4'b1011, 1'b0, 1'b0);
      chk("msb_valid", word_valid, 1);
      chk("msb_word", word_out, 4'b1011);
      word_ready = 1'b1; step(); word_ready = 1'b0;
      step();

      // LSB-first, dir toggled after the first bit
      send_word(1'b0, 1'b0, 4'b1011, 1'b1, 1'b0);
      chk("lsb_word", word_out, 4'b1101);
      word_ready = 1'b1; step(); word_ready = 1'b0;

      // MSB-first, inverted
      send_word(1'b1, 1'b1, 4'b1011, 1'b0, 1'b0);
      chk("inv_word", word_out, 4'b0100);
      chk("inv_perr", parity_err, 0);
      word_ready = 1'b1; step(); word_ready = 1'b0;

      // back-pressure: A held, B assembles up to its final beat
      send_word(1'b1, 1'b0, 4'b1011, 1'b0, 1'b0);
      inv = 1'b0;
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
`ifdef SHIFT4_RX_PARITY_EN
      send_bit(1'b0);
`endif
      sin_valid = 1'b1;
      sin_data  = 1'b0;
      #1;
      chk("bp_ready_low", sin_ready, 0);
      chk("bp_hold_a", word_out, 4'b1011);
      step();
      chk("bp_still_held", word_out, 4'b1011);
      word_ready = 1'b1;
      #1;
      chk("bp_ready_high", sin_ready, 1);
      step();
      sin_valid  = 1'b0;
      word_ready = 1'b0;
      chk("bp_valid_b", word_valid, 1);
      chk("bp_word_b", word_out, 4'b0110);
      word_ready = 1'b1; step(); word_ready = 1'b0;

      // reset mid-word with a word held
      send_word(1'b1, 1'b0, 4'b1001, 1'b0, 1'b0);
      send_bit(1'b1); send_bit(1'b1);
      reset = 1'b0; step(); reset = 1'b1;
      chk("rst2_valid", word_valid, 0);
      chk("rst2_word", word_out, 0);
      send_word(1'b1, 1'b0, 4'b0110, 1'b0, 1'b0);
      chk("rst2_new_word", word_out, 4'b0110);
      word_ready = 1'b1; step(); word_ready = 1'b0;

`ifdef SHIFT4_RX_PARITY_EN
      send_word(1'b1, 1'b0, 4'b1011, 1'b0, 1'b0);
      chk("par_ok_word", word_out, 4'b1011);
      chk("par_ok_err", parity_err, 0);
      word_ready = 1'b1; step(); word_ready = 1'b0;
      send_word(1'b1, 1'b0, 4'b1011, 1'b0, 1'b1);
      chk("par_bad_word", word_out, 4'b1011);
      chk("par_bad_err", parity_err, 1);
      word_ready = 1'b1; step(); word_ready = 1'b0;
`else
      chk("par_off_err", parity_err, 0);
`endif

      // random traffic with occasional reset
      repeat (600) begin
         sin_valid  = ($urandom_range(0, 3) != 0);
         sin_data   = 1'($urandom);
         dir        = 1'($urandom);
         inv        = 1'($urandom);
         word_ready = ($urandom_range(0, 2) == 0);
         reset      = ($urandom_range(0, 60) != 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
